// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg
// Shared definitions for the HI/LO multiply/divide unit. The ALU decode and
// the control unit import this package as well.
//   muldiv_op_t    : op encodings carried on the op port (MULT, MULTU, DIV, DIVU)
//   muldiv_state_t : FSM states of mips_muldiv_unit
package mips_muldiv_pkg;

  localparam logic [1:0] OP_ENC_MULT  = 2'b00;
  localparam logic [1:0] OP_ENC_MULTU = 2'b01;
  localparam logic [1:0] OP_ENC_DIV   = 2'b10;
  localparam logic [1:0] OP_ENC_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MULT  = OP_ENC_MULT,
    MULTU = OP_ENC_MULTU,
    DIV   = OP_ENC_DIV,
    DIVU  = OP_ENC_DIVU
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t o);
    return (o == DIV) || (o == DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t o);
    return (o == MULT) || (o == DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// muldiv_step
// One combinational radix-2 step on the {accumulator, operand} pair.
//   is_div  in  : 1 = restoring shift-subtract step, 0 = shift-add step
//   acc_in  in  : 2*WIDTH accumulator; mul {partial, multiplier}, div {rem, dividend/quotient}
//   operand in  : multiplicand (mul) or divisor (div) magnitude
//   acc_out out : accumulator after one step
module muldiv_step
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] cand;
  logic [WIDTH:0] diff;

  always_comb begin
    // mul: add multiplicand when the multiplier LSB is set, then shift the
    // whole {carry, partial, multiplier} right by one
    sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, (acc_in[0] ? operand : '0)};
    // div: shift the next dividend bit into the remainder and try to subtract
    cand = acc_in[2*WIDTH-1:WIDTH-1];
    diff = cand - {1'b0, operand};
    if (is_div) begin
      if (diff[WIDTH]) acc_out = {cand[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      else             acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
// Iterative multiply/divide unit owning the MIPS HI/LO registers.
//   clk, reset (sync, active-high)
//   start, op, a, b    : launch MULT/MULTU/DIV/DIVU, sampled only when not busy
//   hi_we, lo_we, wdata: MTHI/MTLO writes, honoured only in IDLE
//   busy               : operation in flight (N+1 cycles, N = WIDTH/BITS_PER_CYCLE)
//   done               : one-cycle pulse with the new HI/LO visible
//   div_by_zero        : pulses with done for a zero divisor; HI/LO untouched
//   hi, lo             : HI and LO registers
//
// state | meaning
// IDLE  | accepts start and MTHI/MTLO
// CALC  | BITS_PER_CYCLE steps per clock for N clocks
// FIX   | sign correction, HI/LO write, done pulse
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  muldiv_state_t    state;
  muldiv_op_t       op_r;
  logic [WIDTH-1:0] mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             neg_res;
  logic             neg_rem;
  logic             zero_div;

  // operand capture
  muldiv_op_t       op_in;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_in = muldiv_op_t'(op);
  assign a_neg = op_is_signed(op_in) & a[WIDTH-1];
  assign b_neg = op_is_signed(op_in) & b[WIDTH-1];
  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // step chain
  logic                 is_div;
  logic [2*WIDTH-1:0]   chain [BITS_PER_CYCLE+1];

  assign is_div   = op_is_div(op_r);
  assign chain[0] = acc;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .acc_in  (chain[i]),
      .operand (mag_b),
      .acc_out (chain[i+1])
    );
  end

  // sign correction; quotient and remainder are negated independently
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [2*WIDTH-1:0] result;

  assign prod_fix = neg_res ? -acc : acc;
  assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign result   = is_div ? {rem_fix, quot_fix} : prod_fix;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_r        <= MULT;
      mag_b       <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      zero_div    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_r     <= op_in;
            mag_b    <= b_mag;
            acc      <= {{WIDTH{1'b0}}, a_mag};
            cnt      <= '0;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            zero_div <= op_is_div(op_in) && (b == '0);
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= chain[BITS_PER_CYCLE];
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (!zero_div) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
          end
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= zero_div;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit
// Scoreboard bench for mips_muldiv_unit at three configurations:
//   cfg 0: WIDTH=32, BITS_PER_CYCLE=1 (busy 33)
//   cfg 1: WIDTH=32, BITS_PER_CYCLE=4 (busy 9)
//   cfg 2: WIDTH=8,  BITS_PER_CYCLE=2 (busy 5)
// Expected HI/LO come from a behavioural integer model; a negedge monitor
// pops the queue on every done pulse.
module tb_mips_muldiv_unit;

  localparam logic [1:0] T_MULT = 2'b00, T_MULTU = 2'b01, T_DIV = 2'b10, T_DIVU = 2'b11;

  typedef struct {
    int          cfg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a_bus = '0, b_bus = '0, wdata = '0;
  logic [2:0]  start_v = '0, hi_we_v = '0, lo_we_v = '0;
  logic [2:0]  busy_v, done_v, dbz_v;
  logic [31:0] hi0, lo0, hi1, lo1;
  logic [7:0]  hi2, lo2;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mhi[3], mlo[3];
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_c0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .a(a_bus), .b(b_bus),
    .hi_we(hi_we_v[0]), .lo_we(lo_we_v[0]), .wdata(wdata),
    .busy(busy_v[0]), .done(done_v[0]), .div_by_zero(dbz_v[0]), .hi(hi0), .lo(lo0));

  mips_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_c1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .a(a_bus), .b(b_bus),
    .hi_we(hi_we_v[1]), .lo_we(lo_we_v[1]), .wdata(wdata),
    .busy(busy_v[1]), .done(done_v[1]), .div_by_zero(dbz_v[1]), .hi(hi1), .lo(lo1));

  mips_muldiv_unit #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .op(op), .a(a_bus[7:0]), .b(b_bus[7:0]),
    .hi_we(hi_we_v[2]), .lo_we(lo_we_v[2]), .wdata(wdata[7:0]),
    .busy(busy_v[2]), .done(done_v[2]), .div_by_zero(dbz_v[2]), .hi(hi2), .lo(lo2));

  function automatic logic [31:0] rd_hi(input int c);
    case (c)
      0:       return hi0;
      1:       return hi1;
      default: return {24'h0, hi2};
    endcase
  endfunction

  function automatic logic [31:0] rd_lo(input int c);
    case (c)
      0:       return lo0;
      1:       return lo1;
      default: return {24'h0, lo2};
    endcase
  endfunction

  function automatic int wid(input int c);
    return (c == 2) ? 8 : 32;
  endfunction

  function automatic int nlat(input int c);
    case (c)
      0:       return 33;
      1:       return 9;
      default: return 5;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on sign/zero-extended operands.
  task automatic calc(input int c, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      output logic [31:0] rh, output logic [31:0] rl, output logic z);
    int w;
    longint unsigned mask, ux, uy, p;
    longint sx, sy, q, r;
    w    = wid(c);
    mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
    ux   = {32'h0, x} & mask;
    uy   = {32'h0, y} & mask;
    sx   = (w == 32) ? longint'($signed(x)) : longint'($signed(x[7:0]));
    sy   = (w == 32) ? longint'($signed(y)) : longint'($signed(y[7:0]));
    z    = 1'b0;
    rh   = mhi[c];
    rl   = mlo[c];
    case (o)
      T_MULT: begin
        p  = longint'(sx * sy);
        rh = 32'((p >> w) & mask);
        rl = 32'(p & mask);
      end
      T_MULTU: begin
        p  = ux * uy;
        rh = 32'((p >> w) & mask);
        rl = 32'(p & mask);
      end
      default: begin
        if (uy == 0) begin
          z = 1'b1;
        end else if (o == T_DIV) begin
          q  = sx / sy;
          r  = sx % sy;
          rl = 32'(longint'(q) & longint'(mask));
          rh = 32'(longint'(r) & longint'(mask));
        end else begin
          rl = 32'(ux / uy);
          rh = 32'(ux % uy);
        end
      end
    endcase
  endtask

  task automatic issue(input int c, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [31:0] rh, rl;
    logic        z;
    calc(c, o, x, y, rh, rl, z);
    e.cfg      = c;
    e.hi       = rh;
    e.lo       = rl;
    e.dbz      = z;
    e.done_cyc = cyc + nlat(c) + 1;
    mhi[c]     = rh;
    mlo[c]     = rl;
    sb.push_back(e);
    op         = o;
    a_bus      = x;
    b_bus      = y;
    start_v[c] = 1'b1;
    @(negedge clk);
    start_v = '0;
    hi_we_v = '0;
    lo_we_v = '0;
    check("busy_after_start", busy_v[c], 1);
  endtask

  task automatic wait_done(input int c);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_v[c]) break;
    end
    check("done_seen", done_v[c], 1);
  endtask

  task automatic mt(input int c, input bit is_hi, input logic [31:0] d, input bit applies);
    wdata = d;
    if (is_hi) hi_we_v[c] = 1'b1;
    else       lo_we_v[c] = 1'b1;
    @(negedge clk);
    hi_we_v = '0;
    lo_we_v = '0;
    if (applies) begin
      if (is_hi) mhi[c] = (c == 2) ? {24'h0, d[7:0]} : d;
      else       mlo[c] = (c == 2) ? {24'h0, d[7:0]} : d;
    end
    if (is_hi) check("mthi_hi", rd_hi(c), mhi[c]);
    else       check("mtlo_lo", rd_lo(c), mlo[c]);
  endtask

  task automatic op_wait(input int c, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(c, o, x, y);
    wait_done(c);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        if (done_v[c]) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 0, 1);
          end else begin
            mon_e = sb.pop_front();
            check("done_cfg", c, mon_e.cfg);
            check("hi", rd_hi(c), mon_e.hi);
            check("lo", rd_lo(c), mon_e.lo);
            check("div_by_zero", dbz_v[c], mon_e.dbz);
            check("latency", cyc, mon_e.done_cyc);
            check("busy_at_done", busy_v[c], 0);
          end
        end
        if (dbz_v[c] && !done_v[c]) check("dbz_without_done", done_v[c], 1);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nd;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    for (int c = 0; c < 3; c++) begin
      mhi[c] = '0;
      mlo[c] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rst_busy", busy_v[c], 0);
      check("rst_done", done_v[c], 0);
      check("rst_dbz", dbz_v[c], 0);
      check("rst_hi", rd_hi(c), 0);
      check("rst_lo", rd_lo(c), 0);
    end

    // directed, 32-bit radix-2
    op_wait(0, T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi_const", hi0, 32'hFFFF_FFFE);
    check("multu_lo_const", lo0, 32'h0000_0001);
    op_wait(0, T_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_lo_const", lo0, 32'hFFFF_FFEB);
    op_wait(0, T_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_const", lo0, 32'hFFFF_FFFD);
    check("div_hi_const", hi0, 32'hFFFF_FFFF);
    op_wait(0, T_DIVU, 32'd100, 32'd7);
    op_wait(0, T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", lo0, 32'h8000_0000);

    // divide by zero keeps HI/LO; MTHI while busy is ignored
    mt(0, 1'b1, 32'h1234, 1'b1);
    mt(0, 1'b0, 32'h5678, 1'b1);
    issue(0, T_DIVU, 32'd55, 32'd0);
    repeat (3) @(negedge clk);
    mt(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    wait_done(0);
    check("dbz_hi_kept", hi0, 32'h0000_1234);
    check("dbz_lo_kept", lo0, 32'h0000_5678);

    // MTLO in the same cycle as start: write lands, result overwrites later
    lo_we_v[0] = 1'b1;
    wdata      = 32'hCAFE_0001;
    mlo[0]     = 32'hCAFE_0001;
    issue(0, T_DIVU, 32'd9, 32'd0);
    check("mtlo_with_start", lo0, 32'hCAFE_0001);
    wait_done(0);
    lo_we_v[0] = 1'b1;
    issue(0, T_MULTU, 32'd6, 32'd7);
    wait_done(0);

    // back-to-back: start during the done cycle
    issue(0, T_MULT, 32'd12345, 32'hFFFF_FF00);
    wait_done(0);
    issue(0, T_DIV, 32'd1000, 32'hFFFF_FFF3);
    wait_done(0);

    // start while busy is ignored
    issue(0, T_DIVU, 32'd1000, 32'd9);
    repeat (5) @(negedge clk);
    op = T_MULT; a_bus = 32'd3; b_bus = 32'd3; start_v[0] = 1'b1;
    @(negedge clk);
    start_v = '0;
    wait_done(0);

    // reset in the middle of a MULT
    issue(0, T_MULT, 32'h0001_0001, 32'h0000_0FFF);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy_v[0], 0);
    check("abort_hi", hi0, 0);
    check("abort_lo", lo0, 0);
    reset = 1'b0;
    sb.delete();
    for (int c = 0; c < 3; c++) begin
      mhi[c] = '0;
      mlo[c] = '0;
    end
    nd = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done_v != 3'b000) nd++;
    end
    check("done_after_abort", nd, 0);

    // radix-16, 32-bit
    op_wait(1, T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op_wait(1, T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    op_wait(1, T_DIV, 32'hFFFF_FFF9, 32'd2);
    mt(1, 1'b1, 32'h00AB_CDEF, 1'b1);
    op_wait(1, T_DIV, 32'd77, 32'd0);
    issue(1, T_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(1);
    issue(1, T_DIVU, 32'd100, 32'd7);
    wait_done(1);

    // 8-bit, radix-4
    op_wait(2, T_MULT, 32'h0000_00FD, 32'd7);
    op_wait(2, T_DIV, 32'h0000_0080, 32'h0000_00FF);
    op_wait(2, T_DIVU, 32'd100, 32'd7);
    op_wait(2, T_DIVU, 32'd5, 32'd0);

    // random operands, issued back-to-back
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 12; i++) begin
        ro = 2'($urandom_range(0, 3));
        rx = $urandom;
        ry = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        if (c == 2) begin
          rx = rx & 32'hFF;
          ry = ry & 32'hFF;
        end
        issue(c, ro, rx, ry);
        wait_done(c);
      end
    end

    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      check("final_hi", rd_hi(c), mhi[c]);
      check("final_lo", rd_lo(c), mlo[c]);
    end
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
